reg_xfer_datapath: RTL and testbench
====================================

// Module: reg_xfer_datapath
// PURPOSE
//  NREGS x WIDTH register datapath with shared transfer bus. Each register has a debounced
//  load button producing a one-clk load strobe; loaded value is chosen by a global mode
//  (inc/dec self, bus transfer, clear, external data). Sits between board switches/buttons
//  and the 7-segment display driver; replaces fixed 3x4-bit A/B/C datapath.
// PARAMETERS
//  WIDTH      4    register/bus width in bits
//  NREGS      4    number of registers (2..8)
//  SEL_W      2    width of src_sel; 2**SEL_W >= NREGS
//  DEB_TICKS  4    consecutive equal tick samples required to accept a button edge (>=2)
// PORTS
//  clk        in   1              system clock
//  rst_n      in   1              asynchronous reset, active-low
//  tick       in   1              debounce sample strobe (~1 ms, one clk wide)
//  btn        in   NREGS          raw load buttons, bit i -> register i (async)
//  dir        in   NREGS          per-register inc/dec select: 0 = +1, 1 = -1
//  mode       in   2              00 inc/dec, 01 bus transfer, 10 clear, 11 load data_in
//  src_sel    in   SEL_W          bus source register index
//  data_in    in   WIDTH          external load value (mode 11)
//  bus        out  WIDTH          current bus value (combinational)
//  regs_flat  out  NREGS*WIDTH    all registers, reg i at [i*WIDTH +: WIDTH]
//  load_pulse out  NREGS          one-clk load strobes (observability)
//  wrap_flag  out  NREGS          sticky: register i wrapped during inc/dec
//  load_cnt   out  8              total accepted loads, wraps 255->0
// BEHAVIOUR
//  Reset (rst_n=0, async): all regs 0, load_pulse 0, wrap_flag 0, load_cnt 0, debouncers in
//   RELEASED with counter 0, synchronizer flops 0. bus then = 0.
//  Button path per channel: 2-flop synchronizer on btn[i]; FSM advances only on tick=1.
//   RELEASED: sample 1 -> PRESS_CHK, cnt=1.
//   PRESS_CHK: sample 1 -> cnt+1; when cnt reaches DEB_TICKS -> PRESSED and load_pulse[i]=1
//     for exactly the next clk cycle; sample 0 -> RELEASED, cnt=0.
//   PRESSED: sample 0 -> RELEASE_CHK, cnt=1; held button never re-pulses.
//   RELEASE_CHK: sample 0 -> cnt+1; at DEB_TICKS -> RELEASED; sample 1 -> PRESSED.
//  Load: on the clk edge where load_pulse[i]=1, reg[i] <= next value per mode:
//   00: reg[i] +/- 1 mod 2**WIDTH per dir[i]; wrap (max->0 or 0->max) sets wrap_flag[i].
//   01: bus, bus = reg[src_sel] (pre-edge value); src_sel >= NREGS -> bus = 0.
//   10: 0.    11: data_in.
//  Simultaneous pulses: all pulsed registers update on same edge from pre-edge values
//   (e.g. mode 01 loading the source register itself leaves it unchanged).
//  wrap_flag cleared only by reset or mode 10 load of that register.
//  load_cnt += popcount(load_pulse) each clk, modulo 256.
//  Latency: DEB_TICKS-th stable tick -> pulse next clk -> register visible one clk later.
//  Glitch shorter than DEB_TICKS ticks: no pulse, no state change outside the FSM.
//  Reset mid-debounce or mid-pulse: pulse dropped immediately, no load occurs.
// TESTING
//  1 WIDTH=4, reg0=15, dir0=0, mode 00, hold btn0 6 ticks -> one pulse, reg0=0, wrap_flag0=1, load_cnt=1.
//  2 btn1 high for 2 ticks then low (DEB_TICKS=4) -> no load_pulse, reg1 unchanged.
//  3 mode 11, data_in=9, press btn2 -> reg2=9; mode 01, src_sel=2, press btn0 -> reg0=9.
//  4 reg0=3, reg1=5, mode 01, src_sel=0, btn0 and btn1 pulse same cycle -> reg0=3, reg1=3, load_cnt+=2.
//  5 btn held 100 ticks -> exactly one pulse; release and re-press -> second pulse.
//  6 assert rst_n=0 during PRESS_CHK and again in pulse cycle -> no load, all outputs 0.

Source files
------------

// File: rtl/reg_xfer_datapath.sv
// NREGS x WIDTH register datapath with a shared transfer bus.
// Each register is loaded by a debounced one-clock button strobe; the global mode selects the new value.
module reg_xfer_datapath #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned NREGS     = 4,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned DEB_TICKS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick,
  input  logic [NREGS-1:0]       btn,
  input  logic [NREGS-1:0]       dir,
  input  logic [1:0]             mode,
  input  logic [SEL_W-1:0]       src_sel,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH-1:0]       bus,
  output logic [NREGS*WIDTH-1:0] regs_flat,
  output logic [NREGS-1:0]       load_pulse,
  output logic [NREGS-1:0]       wrap_flag,
  output logic [7:0]             load_cnt
);

  localparam int unsigned CNT_W = $clog2(DEB_TICKS + 1);

  localparam logic [1:0] MODE_INCDEC = 2'b00;
  localparam logic [1:0] MODE_BUS    = 2'b01;
  localparam logic [1:0] MODE_CLEAR  = 2'b10;
  localparam logic [1:0] MODE_DATA   = 2'b11;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } deb_state_t;

  logic [NREGS-1:0] sync1_q;
  logic [NREGS-1:0] sync2_q;
  deb_state_t       state_q [NREGS];
  deb_state_t       state_d [NREGS];
  logic [CNT_W-1:0] cnt_q   [NREGS];
  logic [CNT_W-1:0] cnt_d   [NREGS];
  logic [NREGS-1:0] pulse_d;
  logic [WIDTH-1:0] reg_q   [NREGS];
  logic [WIDTH-1:0] reg_d   [NREGS];
  logic [NREGS-1:0] wrap_d;
  logic [7:0]       cnt_add;

  // Two-flop synchronizer for the asynchronous buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Debounce state registers; the load strobe is registered so it lasts exactly one clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        state_q[i] <= RELEASED;
        cnt_q[i]   <= '0;
      end
      load_pulse <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      load_pulse <= pulse_d;
    end
  end

  // Debounce next-state: advances only on tick samples
  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (tick) begin
        case (state_q[i])
          RELEASED: begin
            if (sync2_q[i]) begin
              state_d[i] = PRESS_CHK;
              cnt_d[i]   = CNT_W'(1);
            end
          end
          PRESS_CHK: begin
            if (sync2_q[i]) begin
              if (CNT_W'(cnt_q[i] + CNT_W'(1)) == CNT_W'(DEB_TICKS)) begin
                state_d[i] = PRESSED;
                cnt_d[i]   = '0;
                pulse_d[i] = 1'b1;
              end else begin
                cnt_d[i] = CNT_W'(cnt_q[i] + CNT_W'(1));
              end
            end else begin
              state_d[i] = RELEASED;
              cnt_d[i]   = '0;
            end
          end
          PRESSED: begin
            if (!sync2_q[i]) begin
              state_d[i] = RELEASE_CHK;
              cnt_d[i]   = CNT_W'(1);
            end
          end
          RELEASE_CHK: begin
            if (!sync2_q[i]) begin
              if (CNT_W'(cnt_q[i] + CNT_W'(1)) == CNT_W'(DEB_TICKS)) begin
                state_d[i] = RELEASED;
                cnt_d[i]   = '0;
              end else begin
                cnt_d[i] = CNT_W'(cnt_q[i] + CNT_W'(1));
              end
            end else begin
              state_d[i] = PRESSED;
              cnt_d[i]   = '0;
            end
          end
          default: begin
            state_d[i] = RELEASED;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Shared bus: out-of-range source index reads as zero
  always_comb begin
    bus = '0;
    for (int j = 0; j < NREGS; j++) begin
      if (src_sel == SEL_W'(j)) bus = reg_q[j];
    end
  end

  // Next register values, all computed from pre-edge state
  always_comb begin
    cnt_add = '0;
    for (int i = 0; i < NREGS; i++) begin
      reg_d[i]  = reg_q[i];
      wrap_d[i] = wrap_flag[i];
      cnt_add   = cnt_add + 8'(load_pulse[i]);
      if (load_pulse[i]) begin
        case (mode)
          MODE_INCDEC: begin
            if (dir[i]) begin
              reg_d[i] = reg_q[i] - WIDTH'(1);
              if (reg_q[i] == '0) wrap_d[i] = 1'b1;
            end else begin
              reg_d[i] = reg_q[i] + WIDTH'(1);
              if (&reg_q[i]) wrap_d[i] = 1'b1;
            end
          end
          MODE_BUS:   reg_d[i] = bus;
          MODE_CLEAR: begin
            reg_d[i]  = '0;
            wrap_d[i] = 1'b0;
          end
          MODE_DATA:  reg_d[i] = data_in;
          default:    reg_d[i] = reg_q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) reg_q[i] <= '0;
      wrap_flag <= '0;
      load_cnt  <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) reg_q[i] <= reg_d[i];
      wrap_flag <= wrap_d;
      load_cnt  <= load_cnt + cnt_add;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NREGS; i++) regs_flat[i*WIDTH +: WIDTH] = reg_q[i];
  end

endmodule

// File: tb/tb_reg_xfer_datapath.sv
// Scoreboard bench for reg_xfer_datapath: stimulus pushes expected post-load state,
// a monitor pops and compares one clock after each observed load strobe.
module tb_reg_xfer_datapath;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [3:0]  btn = '0;
  logic [3:0]  dir = '0;
  logic [1:0]  mode = '0;
  logic [1:0]  src_sel = '0;
  logic [3:0]  data_in = '0;
  logic [3:0]  bus;
  logic [15:0] regs_flat;
  logic [3:0]  load_pulse;
  logic [3:0]  wrap_flag;
  logic [7:0]  load_cnt;

  reg_xfer_datapath #(.WIDTH(4), .NREGS(4), .SEL_W(2), .DEB_TICKS(4)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn(btn), .dir(dir), .mode(mode),
    .src_sel(src_sel), .data_in(data_in), .bus(bus), .regs_flat(regs_flat),
    .load_pulse(load_pulse), .wrap_flag(wrap_flag), .load_cnt(load_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] regs;
    logic [3:0]  wrap;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  m_regs [4];
  logic [3:0]  m_wrap = '0;
  logic [7:0]  m_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] reg_of(input int i);
    logic [15:0] f;
    f = regs_flat;
    return f[i*4 +: 4];
  endfunction

  // Reference model of one load event on the channels in mask
  task automatic expect_load(input logic [3:0] mask);
    logic [3:0]  pre [4];
    logic [3:0]  busv;
    exp_t        e;
    for (int i = 0; i < 4; i++) pre[i] = m_regs[i];
    busv = pre[src_sel];
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        m_cnt = m_cnt + 8'd1;
        case (mode)
          2'b00: begin
            if (dir[i]) begin
              if (pre[i] == 4'd0) m_wrap[i] = 1'b1;
              m_regs[i] = pre[i] - 4'd1;
            end else begin
              if (pre[i] == 4'd15) m_wrap[i] = 1'b1;
              m_regs[i] = pre[i] + 4'd1;
            end
          end
          2'b01: m_regs[i] = busv;
          2'b10: begin m_regs[i] = 4'd0; m_wrap[i] = 1'b0; end
          default: m_regs[i] = data_in;
        endcase
      end
    end
    e.mask = mask;
    e.regs = {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    e.wrap = m_wrap;
    e.cnt  = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  task automatic press(input logic [3:0] mask, input int hold);
    expect_load(mask);
    btn = btn | mask;
    tick_n(hold);
    btn = btn & ~mask;
    tick_n(6);
  endtask

  // Monitor: every strobe must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && load_pulse != 4'd0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got 0x%0h expected none", load_pulse);
        end else begin
          e = exp_q.pop_front();
          check("pulse_mask", 32'(load_pulse), 32'(e.mask));
          @(posedge clk);
          #1;
          check("regs_after_load", 32'(regs_flat), 32'(e.regs));
          check("wrap_after_load", 32'(wrap_flag), 32'(e.wrap));
          check("cnt_after_load", 32'(load_cnt), 32'(e.cnt));
          check("pulse_one_clk", 32'(load_pulse), 32'd0);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    repeat (3) @(negedge clk);
    check("reset_regs", 32'(regs_flat), 32'd0);
    check("reset_pulse", 32'(load_pulse), 32'd0);
    check("reset_wrap", 32'(wrap_flag), 32'd0);
    check("reset_cnt", 32'(load_cnt), 32'd0);
    check("reset_bus", 32'(bus), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Increment wrap 15 -> 0
    mode = 2'b11; data_in = 4'd15;
    press(4'b0001, 6);
    mode = 2'b00; dir = 4'b0000;
    press(4'b0001, 6);
    check("t1_reg0", 32'(reg_of(0)), 32'd0);
    check("t1_wrap0", 32'(wrap_flag), 32'h1);
    check("t1_cnt", 32'(load_cnt), 32'd2);

    // Short glitch must not load
    btn[1] = 1'b1;
    tick_n(2);
    btn[1] = 1'b0;
    tick_n(6);
    check("t2_reg1", 32'(reg_of(1)), 32'd0);
    check("t2_cnt", 32'(load_cnt), 32'd2);

    // External load then bus transfer
    mode = 2'b11; data_in = 4'd9;
    press(4'b0100, 6);
    check("t3_reg2", 32'(reg_of(2)), 32'd9);
    mode = 2'b01; src_sel = 2'd2;
    @(negedge clk);
    check("t3_bus", 32'(bus), 32'd9);
    press(4'b0001, 6);
    check("t3_reg0", 32'(reg_of(0)), 32'd9);

    // Decrement wrap 0 -> 15, then clear removes wrap flag of reg0
    mode = 2'b00; dir = 4'b0010;
    press(4'b0010, 6);
    check("dec_reg1", 32'(reg_of(1)), 32'd15);
    check("dec_wrap", 32'(wrap_flag), 32'h3);
    mode = 2'b10;
    press(4'b0001, 6);
    check("clr_reg0", 32'(reg_of(0)), 32'd0);
    check("clr_wrap", 32'(wrap_flag), 32'h2);

    // Simultaneous transfer from a register into itself and another
    mode = 2'b11; data_in = 4'd3;
    press(4'b0001, 6);
    data_in = 4'd5;
    press(4'b0010, 6);
    mode = 2'b01; src_sel = 2'd0;
    press(4'b0011, 6);
    check("t4_reg0", 32'(reg_of(0)), 32'd3);
    check("t4_reg1", 32'(reg_of(1)), 32'd3);
    check("t4_cnt", 32'(load_cnt), 32'd10);

    // Long hold gives one pulse; re-press gives another
    mode = 2'b00; dir = 4'b0000;
    press(4'b1000, 100);
    press(4'b1000, 6);
    check("t5_reg3", 32'(reg_of(3)), 32'd2);
    check("t5_cnt", 32'(load_cnt), 32'd12);

    // Reset during PRESS_CHK
    btn[0] = 1'b1;
    tick_n(2);
    rst_n = 1'b0;
    #1;
    btn[0] = 1'b0;
    check("t6a_regs", 32'(regs_flat), 32'd0);
    check("t6a_cnt", 32'(load_cnt), 32'd0);
    check("t6a_wrap", 32'(wrap_flag), 32'd0);
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_wrap = '0; m_cnt = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick_n(6);
    check("t6a_no_pulse_cnt", 32'(load_cnt), 32'd0);

    // Reset in the pulse cycle itself
    btn[0] = 1'b1;
    tick_n(3);
    repeat (3) @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    check("t6b_pulse_seen", 32'(load_pulse), 32'h1);
    rst_n = 1'b0;
    #1;
    btn[0] = 1'b0;
    check("t6b_pulse_dropped", 32'(load_pulse), 32'd0);
    check("t6b_regs", 32'(regs_flat), 32'd0);
    check("t6b_cnt", 32'(load_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick_n(6);
    check("t6b_after_cnt", 32'(load_cnt), 32'd0);
    check("t6b_after_bus", 32'(bus), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
